// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder slice.
//   - state_t : FSM state encoding (IDLE / RUN / DONE)
//   - cnt_width() : bit-position counter width for a given operand width
//   - CNT_W : counter width at the default operand width (8)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;

  // Counter must index bit positions 0..w-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell
//   Combinational 1-bit full adder built from two half-adder stages plus an OR.
//   Ports:
//     a, b  : operand bits
//     cin   : carry in
//     s     : sum bit
//     cout  : carry out (majority of a, b, cin)
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s1, c1, c2;

  // First half-adder stage: a + b
  assign s1 = a ^ b;
  assign c1 = a & b;

  // Second half-adder stage: partial sum + cin
  assign s  = s1 ^ cin;
  assign c2 = s1 & cin;

  assign cout = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder cell plus a carry flip-flop processes the
//   operands LSB first, one bit per clock, behind a start/busy/done handshake.
//   Optional macro SERIAL_ADDER_SUB_EN: when defined, sub=1 computes A-B
//   (B inverted, carry-in 1); when undefined, sub is ignored and A+B is computed.
//   Ports:
//     clk      : rising-edge clock
//     reset    : synchronous active-high reset
//     start    : request, sampled only when not busy
//     A, B     : operands, captured on an accepted start
//     sub      : subtract request, captured on an accepted start
//     busy     : high while computing
//     done     : one-cycle pulse, result outputs valid
//     sum      : result, held until the next completion
//     carry    : carry out of the MSB (no-borrow flag when subtracting)
//     overflow : signed overflow (carry into MSB xor carry out of MSB)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic [CW-1:0]    cnt;
  logic             c_ff;
  logic             sub_eff;
  logic             accept;
  logic             bit_s, bit_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  serial_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_ff),
    .s    (bit_s),
    .cout (bit_c)
  );

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start && (state != ST_RUN);

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start) state_n = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_n = ST_DONE;
      ST_DONE: state_n = start ? ST_RUN : ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // b_sr holds the already-conditioned operand (B or ~B) so the RUN datapath
  // is identical for add and subtract.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      cnt      <= '0;
      c_ff     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_sr <= A;
        b_sr <= sub_eff ? ~B : B;
        c_ff <= sub_eff;
        cnt  <= '0;
      end else if (state == ST_RUN) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        res_sr <= {bit_s, res_sr[WIDTH-1:1]};
        c_ff   <= bit_c;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          sum      <= {bit_s, res_sr[WIDTH-1:1]};
          carry    <= bit_c;
          overflow <= c_ff ^ bit_c;
        end
      end
    end
  end

endmodule
